// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with a valid-qualified input,
// selectable overlapping/non-overlapping detection and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sequence_in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               detector_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               err_q, err_d;
  logic               det_q, det_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic [MAX_LEN-1:0] hist_sh;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic               match;
  logic               len_bad;

  always_comb begin
    accept   = in_valid & ~cfg_load;
    hist_sh  = {hist_q[MAX_LEN-2:0], sequence_in};
    fill_inc = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    mask     = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len_q));
    end
    // The compare looks at the post-shift history so the pulse follows the completing bit by one edge.
    match   = accept && !err_q && (fill_inc >= len_q) &&
              ((hist_sh & mask) == (pat_q & mask));
    len_bad = (cfg_len < LEN_W'(2)) || (cfg_len > LEN_W'(MAX_LEN));
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    err_d  = err_q;
    det_d  = match;
    cnt_d  = cnt_q;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      err_d  = len_bad;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_sh;
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
    end

    if (count_clr) begin
      cnt_d = match ? CNT_W'(1) : '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= '0;
      len_q  <= LEN_W'(MAX_LEN);
      ovl_q  <= 1'b1;
      err_q  <= 1'b0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      err_q  <= err_d;
      det_q  <= det_d;
      cnt_q  <= cnt_d;
    end
  end

  assign detector_out = det_q;
  assign match_count  = cnt_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: expected pulses are queued as
// stimulus is driven and popped when the corresponding output cycle is sampled.
module tb_seq_detector_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_W   = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic               sequence_in;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               count_clr;
  logic               detector_out;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  seq_detector_param #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sequence_in (sequence_in),
    .in_valid    (in_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .count_clr   (count_clr),
    .detector_out(detector_out),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  always #5 clock = ~clock;

  // One clock: drive inputs, queue the expected pulse, sample #1 after the edge.
  task automatic step(input bit v, input bit valid, input bit exp_det, input string tag);
    bit e;
    sequence_in = v;
    in_valid    = valid;
    exp_q.push_back(exp_det);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (detector_out !== e) begin
      n_fail++;
      $display("FAIL %s: detector_out=%b expected %b at %0t", tag, detector_out, e, $time);
    end
    in_valid  = 1'b0;
    count_clr = 1'b0;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                      input bit ovl, input bit clr);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    count_clr   = clr;
    step(1'b0, 1'b0, 1'b0, "load");
    cfg_load = 1'b0;
  endtask

  task automatic check_count(input logic [CNT_W-1:0] exp_c, input string tag);
    n_checks++;
    if (match_count !== exp_c) begin
      n_fail++;
      $display("FAIL %s: match_count=%0d expected %0d", tag, match_count, exp_c);
    end
  endtask

  task automatic check_err(input bit exp_e, input string tag);
    n_checks++;
    if (cfg_err !== exp_e) begin
      n_fail++;
      $display("FAIL %s: cfg_err=%b expected %b", tag, cfg_err, exp_e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, "reset_cycle");
    reset = 1'b0;
  endtask

  // Default config after reset: pattern 0, len MAX_LEN, overlapping.
  task automatic test_reset();
    do_reset();
    check_count('0, "reset_count");
    check_err(1'b0, "reset_err");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, "pre_reset_zeros");
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, "default_fill");
    step(1'b0, 1'b1, 1'b1, "default_match");
    step(1'b0, 1'b1, 1'b1, "default_overlap");
    check_count(CNT_W'(2), "default_count");
  endtask

  task automatic test_overlap();
    bit bits[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit exp[7]  = '{0, 0, 0, 1, 0, 0, 1};
    load(8'b1011, 4'd4, 1'b1, 1'b1);
    check_count('0, "ovl_clr_on_load");
    foreach (bits[i]) step(bits[i], 1'b1, exp[i], "overlap");
    check_count(CNT_W'(2), "overlap_count");
  endtask

  task automatic test_non_overlap();
    bit bits[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit exp[7]  = '{0, 0, 0, 1, 0, 0, 0};
    load(8'b1011, 4'd4, 1'b0, 1'b1);
    foreach (bits[i]) step(bits[i], 1'b1, exp[i], "non_overlap");
    check_count(CNT_W'(1), "non_overlap_count");
  endtask

  task automatic test_gaps();
    load(8'b111, 4'd3, 1'b1, 1'b1);
    for (int b = 0; b < 3; b++) begin
      step(1'b1, 1'b1, (b == 2), "gap_bit");
      for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b0, "gap_idle");
    end
    check_count(CNT_W'(1), "gap_count");
  endtask

  task automatic test_saturate();
    load(8'b11, 4'd2, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, (i > 0), "sat_stream");
    check_count(CNT_W'(3), "sat_count");
    count_clr = 1'b1;
    step(1'b1, 1'b1, 1'b1, "clr_with_match");
    check_count(CNT_W'(1), "clr_with_match_count");
    count_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0, "clr_no_match");
    check_count('0, "clr_no_match_count");
  endtask

  task automatic test_cfg_err();
    load(8'hFF, 4'd0, 1'b1, 1'b1);
    check_err(1'b1, "err_len0");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, "err_len0_stream");
    load(8'hFF, LEN_W'(MAX_LEN + 1), 1'b1, 1'b0);
    check_err(1'b1, "err_len_max1");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, "err_lenmax1_stream");
    check_count('0, "err_count");
    load(8'b1011, 4'd4, 1'b1, 1'b0);
    check_err(1'b0, "err_cleared");
    step(1'b1, 1'b1, 1'b0, "resume");
    step(1'b0, 1'b1, 1'b0, "resume");
    step(1'b1, 1'b1, 1'b0, "resume");
    step(1'b1, 1'b1, 1'b1, "resume_match");
  endtask

  // The bit offered on the load cycle must be discarded.
  task automatic test_load_discard();
    cfg_pattern = 8'b11;
    cfg_len     = 4'd2;
    cfg_overlap = 1'b1;
    cfg_load    = 1'b1;
    step(1'b1, 1'b1, 1'b0, "load_with_valid");
    cfg_load = 1'b0;
    step(1'b1, 1'b1, 1'b0, "discard_first");
    step(1'b1, 1'b1, 1'b1, "discard_second");
  endtask

  task automatic test_reset_mid_pattern();
    load(8'b1011, 4'd4, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, "pre_rst");
    step(1'b0, 1'b1, 1'b0, "pre_rst");
    step(1'b1, 1'b1, 1'b0, "pre_rst");
    do_reset();
    check_count('0, "mid_rst_count");
    check_err(1'b0, "mid_rst_err");
    load(8'b1011, 4'd4, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, "post_rst");
    step(1'b0, 1'b1, 1'b0, "post_rst");
    step(1'b1, 1'b1, 1'b0, "post_rst");
    step(1'b1, 1'b1, 1'b1, "post_rst_match");
    check_count(CNT_W'(1), "post_rst_count");
  endtask

  initial begin
    reset       = 1'b0;
    sequence_in = 1'b0;
    in_valid    = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    count_clr   = 1'b0;
    #1;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_gaps();
    test_saturate();
    test_cfg_err();
    test_load_discard();
    test_reset_mid_pattern();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
